// File: rtl/btn_pkg.sv
// Shared types and default timing constants for the push-button conditioner.
// Defaults assume a 100 MHz system clock.
package btn_pkg;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        HELD         = 2'd2,
        RELEASE_WAIT = 2'd3
    } btn_state_t;

    localparam int unsigned CLK_HZ              = 32'd100_000_000;
    localparam int unsigned DEBOUNCE_10MS       = CLK_HZ / 32'd100;
    localparam int unsigned REPEAT_DELAY_500MS  = CLK_HZ / 32'd2;
    localparam int unsigned REPEAT_PERIOD_100MS = CLK_HZ / 32'd10;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        if (a > b) begin
            return a;
        end else begin
            return b;
        end
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous bit.
// Both flops clear to 0 on a synchronous active-low reset.
module sync_2ff (
    input  logic clk_in,
    input  logic rst_n_in,
    input  logic d_in,
    output logic q_out
);

    logic meta_q;
    logic meta_d;
    logic sync_q;
    logic sync_d;

    // Next-state for the shift chain.
    always_comb begin
        meta_d = d_in;
        sync_d = meta_q;
    end

    // Synchronizer flops with synchronous reset.
    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q_out = sync_q;

endmodule

// File: rtl/button_conditioner.sv
// Debounces a raw push-button into a clean level plus one-cycle press pulses,
// with optional hold-to-auto-repeat.
module button_conditioner
    import btn_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES      = DEBOUNCE_10MS,
    parameter int unsigned REPEAT_EN            = 32'd1,
    parameter int unsigned REPEAT_DELAY_CYCLES  = REPEAT_DELAY_500MS,
    parameter int unsigned REPEAT_PERIOD_CYCLES = REPEAT_PERIOD_100MS
) (
    input  logic clk_in,
    input  logic rst_n_in,
    input  logic btn_raw_in,
    output logic btn_level,
    output logic btn_pulse
);

    localparam int unsigned DW = $clog2(DEBOUNCE_CYCLES + 32'd1);
    localparam int unsigned RW = $clog2(max_u(REPEAT_DELAY_CYCLES, REPEAT_PERIOD_CYCLES) + 32'd1);

    localparam logic [DW-1:0] DCNT_LAST = DW'(DEBOUNCE_CYCLES - 32'd1);
    localparam logic [RW-1:0] RDLY_LAST = RW'(REPEAT_DELAY_CYCLES - 32'd1);
    localparam logic [RW-1:0] RPER_LAST = RW'(REPEAT_PERIOD_CYCLES - 32'd1);

    if ((DEBOUNCE_CYCLES == 32'd0) || (REPEAT_DELAY_CYCLES == 32'd0) ||
        (REPEAT_PERIOD_CYCLES == 32'd0)) begin : g_bad_params
        $error("button_conditioner: all cycle parameters must be >= 1");
    end

    logic          s_sync;
    btn_state_t    state_q;
    btn_state_t    state_d;
    logic [DW-1:0] dcnt_q;
    logic [DW-1:0] dcnt_d;
    logic [RW-1:0] rcnt_q;
    logic [RW-1:0] rcnt_d;
    logic          first_q;
    logic          first_d;
    logic          level_q;
    logic          level_d;
    logic          pulse_q;
    logic          pulse_d;
    logic [RW-1:0] rcnt_last_s;

    sync_2ff u_sync (
        .clk_in   (clk_in),
        .rst_n_in (rst_n_in),
        .d_in     (btn_raw_in),
        .q_out    (s_sync)
    );

    // First repeat waits the long delay; later ones use the shorter period.
    always_comb begin
        if (first_q) begin
            rcnt_last_s = RPER_LAST;
        end else begin
            rcnt_last_s = RDLY_LAST;
        end
    end

    // Debounce / repeat FSM next-state logic.
    always_comb begin
        state_d = state_q;
        dcnt_d  = dcnt_q;
        rcnt_d  = rcnt_q;
        first_d = first_q;
        level_d = level_q;
        pulse_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (s_sync) begin
                    state_d = PRESS_WAIT;
                    dcnt_d  = '0;
                end else begin
                    state_d = IDLE;
                end
            end
            PRESS_WAIT: begin
                if (!s_sync) begin
                    state_d = IDLE;
                end else if (dcnt_q == DCNT_LAST) begin
                    state_d = HELD;
                    level_d = 1'b1;
                    pulse_d = 1'b1;
                    rcnt_d  = '0;
                    first_d = 1'b0;
                end else begin
                    dcnt_d = dcnt_q + DW'(1);
                end
            end
            HELD: begin
                if (!s_sync) begin
                    state_d = RELEASE_WAIT;
                    dcnt_d  = '0;
                end else if (REPEAT_EN != 32'd0) begin
                    if (rcnt_q == rcnt_last_s) begin
                        pulse_d = 1'b1;
                        rcnt_d  = '0;
                        first_d = 1'b1;
                    end else begin
                        rcnt_d = rcnt_q + RW'(1);
                    end
                end else begin
                    state_d = HELD;
                end
            end
            RELEASE_WAIT: begin
                // A bounce back high resumes the hold without a new pulse.
                if (s_sync) begin
                    state_d = HELD;
                end else if (dcnt_q == DCNT_LAST) begin
                    state_d = IDLE;
                    level_d = 1'b0;
                    rcnt_d  = '0;
                    first_d = 1'b0;
                end else begin
                    dcnt_d = dcnt_q + DW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                dcnt_d  = '0;
                rcnt_d  = '0;
                first_d = 1'b0;
                level_d = 1'b0;
            end
        endcase
    end

    // FSM state, counters and registered outputs.
    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            state_q <= IDLE;
            dcnt_q  <= '0;
            rcnt_q  <= '0;
            first_q <= 1'b0;
            level_q <= 1'b0;
            pulse_q <= 1'b0;
        end else begin
            state_q <= state_d;
            dcnt_q  <= dcnt_d;
            rcnt_q  <= rcnt_d;
            first_q <= first_d;
            level_q <= level_d;
            pulse_q <= pulse_d;
        end
    end

    assign btn_level = level_q;
    assign btn_pulse = pulse_q;

endmodule

// File: tb/tb_button_conditioner.sv
// Randomized bench for button_conditioner: three parameter sets share one raw
// input and are compared every cycle against a run-length reference model.
module tb_button_conditioner;

    logic       clk_in = 1'b0;
    logic       rst_n_in;
    logic       btn_raw_in;
    logic [2:0] lvl_o;
    logic [2:0] pul_o;

    always #5 clk_in = ~clk_in;

    button_conditioner #(
        .DEBOUNCE_CYCLES(4), .REPEAT_EN(0), .REPEAT_DELAY_CYCLES(10), .REPEAT_PERIOD_CYCLES(3)
    ) dut_norep (
        .clk_in(clk_in), .rst_n_in(rst_n_in), .btn_raw_in(btn_raw_in),
        .btn_level(lvl_o[0]), .btn_pulse(pul_o[0])
    );

    button_conditioner #(
        .DEBOUNCE_CYCLES(4), .REPEAT_EN(1), .REPEAT_DELAY_CYCLES(10), .REPEAT_PERIOD_CYCLES(3)
    ) dut_rep (
        .clk_in(clk_in), .rst_n_in(rst_n_in), .btn_raw_in(btn_raw_in),
        .btn_level(lvl_o[1]), .btn_pulse(pul_o[1])
    );

    button_conditioner #(
        .DEBOUNCE_CYCLES(1), .REPEAT_EN(1), .REPEAT_DELAY_CYCLES(1), .REPEAT_PERIOD_CYCLES(1)
    ) dut_min (
        .clk_in(clk_in), .rst_n_in(rst_n_in), .btn_raw_in(btn_raw_in),
        .btn_level(lvl_o[2]), .btn_pulse(pul_o[2])
    );

    int p_deb[3] = '{4, 4, 1};
    int p_ren[3] = '{0, 1, 1};
    int p_rdl[3] = '{10, 10, 1};
    int p_rpr[3] = '{3, 3, 1};

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    // Reference model: a raw-to-FSM delay line, then per-config run lengths.
    bit m_d1, m_d2;
    bit m_lvl[3];
    bit m_pul[3];
    bit m_prev[3];
    int m_run[3];
    int m_hold[3];

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s cycle %0d: got %b expected %b", tag, cyc, obs, exp);
        end
    endtask

    task automatic model_step(input bit raw, input bit rst_n);
        bit s;
        s = m_d2;
        if (!rst_n) begin
            m_d1 = 1'b0;
            m_d2 = 1'b0;
        end else begin
            m_d2 = m_d1;
            m_d1 = raw;
        end
        for (int i = 0; i < 3; i++) begin
            if (!rst_n) begin
                m_lvl[i]  = 1'b0;
                m_pul[i]  = 1'b0;
                m_prev[i] = 1'b0;
                m_run[i]  = 0;
                m_hold[i] = 0;
            end else begin
                m_pul[i] = 1'b0;
                // Held time counts only cycles continuously high while accepted.
                if (m_lvl[i] && s && m_prev[i] && p_ren[i] != 0) begin
                    m_hold[i]++;
                    if (m_hold[i] == p_rdl[i] ||
                        (m_hold[i] > p_rdl[i] && (m_hold[i] - p_rdl[i]) % p_rpr[i] == 0))
                        m_pul[i] = 1'b1;
                end
                // The level flips once the input has disagreed for D+1 decisions.
                if (s != m_lvl[i]) begin
                    m_run[i]++;
                    if (m_run[i] == p_deb[i] + 1) begin
                        m_lvl[i]  = s;
                        m_run[i]  = 0;
                        m_hold[i] = 0;
                        if (s) m_pul[i] = 1'b1;
                    end
                end else begin
                    m_run[i] = 0;
                end
                m_prev[i] = s;
            end
        end
    endtask

    task automatic tick(input bit raw, input bit rst_n);
        btn_raw_in = raw;
        rst_n_in   = rst_n;
        @(posedge clk_in);
        model_step(raw, rst_n);
        cyc++;
        @(negedge clk_in);
        for (int i = 0; i < 3; i++) begin
            check_bit($sformatf("level%0d", i), lvl_o[i], m_lvl[i]);
            check_bit($sformatf("pulse%0d", i), pul_o[i], m_pul[i]);
        end
    endtask

    task automatic run(input bit raw, input int n);
        for (int k = 0; k < n; k++) tick(raw, 1'b1);
    endtask

    initial begin
        int kind;
        int len;
        rst_n_in   = 1'b0;
        btn_raw_in = 1'b0;
        @(negedge clk_in);
        for (int k = 0; k < 3; k++) tick(1'b0, 1'b0);

        // Clean press and release.
        run(1'b1, 20);
        run(1'b0, 12);
        // Short glitch, then fast toggling.
        run(1'b1, 3);
        run(1'b0, 10);
        for (int k = 0; k < 15; k++) begin
            run(1'b1, 2);
            run(1'b0, 2);
        end
        run(1'b0, 8);
        // Release bounce.
        run(1'b1, 12);
        run(1'b0, 2); run(1'b1, 3); run(1'b0, 1); run(1'b1, 2);
        run(1'b0, 14);
        // Long hold for auto-repeat.
        run(1'b1, 40);
        run(1'b0, 12);
        // Reset while held.
        run(1'b1, 13);
        tick(1'b1, 1'b0);
        tick(1'b1, 1'b0);
        run(1'b1, 20);
        run(1'b0, 12);

        // Random segments.
        for (int seg = 0; seg < 160; seg++) begin
            kind = int'($urandom_range(0, 4));
            case (kind)
                0: run(1'b1, int'($urandom_range(1, 45)));
                1: run(1'b0, int'($urandom_range(1, 15)));
                2: begin
                    len = int'($urandom_range(4, 20));
                    for (int k = 0; k < len; k++) tick(1'($urandom_range(0, 1)), 1'b1);
                end
                3: begin
                    len = int'($urandom_range(1, 3));
                    for (int k = 0; k < len; k++) tick(1'($urandom_range(0, 1)), 1'b0);
                end
                default: begin
                    run(1'b1, int'($urandom_range(8, 30)));
                    len = int'($urandom_range(2, 8));
                    for (int k = 0; k < len; k++) run(1'($urandom_range(0, 1)), int'($urandom_range(1, 3)));
                end
            endcase
        end
        run(1'b0, 12);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
